// File: rtl/contador_ctrl.sv
// -----------------------------------------------------------------------------
// contador_ctrl
//   Sequence counter with run/step control. The counter walks the fixed cycle
//   1 -> 7 -> 0 -> 2 -> 3 -> 1. Any other value (4, 5, 6) recovers to 1 on its
//   next advance. A run moves the counter one position per clock. It stops on
//   a latched target value once the requested number of full wraps (3 -> 1
//   transitions) has completed.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   run request (accepted only in IDLE)
//   stop_req     in   abort request (effective only in RUN)
//   step         in   single-step request (effective only in IDLE, start wins)
//   target[2:0]  in   stop value, latched when start is accepted
//   laps[W-1:0]  in   wraps to complete before stopping, latched with start
//   q[2:0]       out  current sequence value, registered
//   busy         out  high while in RUN
//   done         out  one-cycle pulse on run completion, registered
//   err          out  one-cycle pulse when start is rejected, registered
//   lap_cnt      out  wraps completed in the current or last run
//   o_dbg_state  out  FSM state encoding (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start/stop_req/step are level requests sampled on every rising
// edge. There is no ready signal. A request is either acted on in that edge or
// dropped. done and err are single-cycle registered pulses.
// -----------------------------------------------------------------------------
module contador_ctrl #(
  parameter int LAPS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop_req,
  input  logic              step,
  input  logic [2:0]        target,
  input  logic [LAPS_W-1:0] laps,
  output logic [2:0]        q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LAPS_W-1:0] lap_cnt,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_q, w_q_nxt;
  logic [2:0]          r_tgt, w_tgt_nxt;
  logic [LAPS_W-1:0]   r_laps, w_laps_nxt;
  logic [LAPS_W-1:0]   r_lap, w_lap_nxt;
  logic                r_done, w_done_nxt;
  logic                r_err, w_err_nxt;

  logic [2:0]          w_seq_nxt;
  logic                w_wrap;
  logic [LAPS_W-1:0]   w_lap_inc;
  logic                w_tgt_legal;

  function automatic logic [2:0] seq_next(input logic [2:0] v);
    case (v)
      3'd1:    seq_next = 3'd7;
      3'd7:    seq_next = 3'd0;
      3'd0:    seq_next = 3'd2;
      3'd2:    seq_next = 3'd3;
      3'd3:    seq_next = 3'd1;
      default: seq_next = 3'd1;  // 4, 5, 6 recover to the sequence start
    endcase
  endfunction

  assign w_seq_nxt   = seq_next(r_q);
  assign w_wrap      = (r_q == 3'd3);  // 3 -> 1 closes one full lap
  assign w_lap_inc   = (r_lap == {LAPS_W{1'b1}}) ? r_lap : r_lap + LAPS_W'(1);
  assign w_tgt_legal = (target != 3'd4) && (target != 3'd5) && (target != 3'd6);

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_tgt_nxt   = r_tgt;
    w_laps_nxt  = r_laps;
    w_lap_nxt   = r_lap;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_tgt_legal) begin
            // The counter does not move on the accept edge. The first advance
            // happens in RUN, so a run always takes at least one step.
            w_tgt_nxt   = target;
            w_laps_nxt  = laps;
            w_lap_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (step) begin
          w_q_nxt = w_seq_nxt;
        end
      end

      S_RUN: begin
        if (stop_req) begin
          // Abort beats completion on the same edge. The counter freezes.
          w_state_nxt = S_IDLE;
        end else begin
          w_q_nxt = w_seq_nxt;
          if (w_wrap) w_lap_nxt = w_lap_inc;
          // Completion compares the lap count from before this edge, so
          // landing on target 1 via a wrap still counts that wrap afterwards.
          if ((w_seq_nxt == r_tgt) && (r_lap == r_laps)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_q     <= 3'd1;
      r_tgt   <= '0;
      r_laps  <= '0;
      r_lap   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_tgt   <= w_tgt_nxt;
      r_laps  <= w_laps_nxt;
      r_lap   <= w_lap_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign q           = r_q;
  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign err         = r_err;
  assign lap_cnt     = r_lap;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_contador_ctrl.sv
module tb_contador_ctrl;

  localparam int LAPS_W = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              stop_req;
  logic              step;
  logic [2:0]        target;
  logic [LAPS_W-1:0] laps;
  logic [2:0]        q;
  logic              busy;
  logic              done;
  logic              err;
  logic [LAPS_W-1:0] lap_cnt;
  logic [1:0]        o_dbg_state;

  int n_chk;
  int n_fail;

  contador_ctrl #(.LAPS_W(LAPS_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop_req   (stop_req),
    .step       (step),
    .target     (target),
    .laps       (laps),
    .q          (q),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .lap_cnt    (lap_cnt),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop_req = 1'b0; step = 1'b0; target = 3'd0; laps = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_q", q, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_lap", lap_cnt, 0);
    chk("rst_state", o_dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock edge, then settle before sampling
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic sr, input logic st,
                       input logic [2:0] t, input logic [LAPS_W-1:0] l);
    start = s; stop_req = sr; step = st; target = t; laps = l;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              start;
    logic              stop_req;
    logic              step;
    logic [2:0]        target;
    logic [LAPS_W-1:0] laps;
    logic [2:0]        q;
    logic              busy;
    logic              done;
    logic              err;
    logic [LAPS_W-1:0] lap;
  } vec_t;

  vec_t vecs[16];

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    idle_inputs();

    //              st sr sp tgt laps  q  b  d  e  lap
    vecs[0]  = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd1,1'b0,1'b0,1'b0,4'd0}; // idle, nothing
    vecs[1]  = '{1'b1,1'b0,1'b0,3'd2,4'd0, 3'd1,1'b1,1'b0,1'b0,4'd0}; // accept, no advance
    vecs[2]  = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd7,1'b1,1'b0,1'b0,4'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd0,1'b1,1'b0,1'b0,4'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd2,1'b0,1'b1,1'b0,4'd0}; // done with q=2
    vecs[5]  = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd2,1'b0,1'b0,1'b0,4'd0}; // back to idle
    vecs[6]  = '{1'b1,1'b0,1'b0,3'd4,4'd1, 3'd2,1'b0,1'b0,1'b1,4'd0}; // illegal target
    vecs[7]  = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd2,1'b0,1'b0,1'b0,4'd0}; // err one cycle
    vecs[8]  = '{1'b0,1'b0,1'b1,3'd0,4'd0, 3'd3,1'b0,1'b0,1'b0,4'd0}; // step 2->3
    vecs[9]  = '{1'b0,1'b0,1'b1,3'd0,4'd0, 3'd1,1'b0,1'b0,1'b0,4'd0}; // step 3->1, no lap
    vecs[10] = '{1'b0,1'b1,1'b1,3'd0,4'd0, 3'd7,1'b0,1'b0,1'b0,4'd0}; // stop ignored in idle
    vecs[11] = '{1'b1,1'b0,1'b0,3'd6,4'd0, 3'd7,1'b0,1'b0,1'b1,4'd0}; // illegal target 6
    vecs[12] = '{1'b1,1'b0,1'b1,3'd0,4'd0, 3'd7,1'b1,1'b0,1'b0,4'd0}; // start beats step
    vecs[13] = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd0,1'b0,1'b1,1'b0,4'd0}; // 7->0 completes
    vecs[14] = '{1'b0,1'b0,1'b0,3'd0,4'd0, 3'd0,1'b0,1'b0,1'b0,4'd0};
    vecs[15] = '{1'b0,1'b1,1'b0,3'd0,4'd0, 3'd0,1'b0,1'b0,1'b0,4'd0}; // stop in idle

    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].start, vecs[i].stop_req, vecs[i].step, vecs[i].target, vecs[i].laps);
      cyc();
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].done);
      chk($sformatf("v%0d_err", i), err, vecs[i].err);
      chk($sformatf("v%0d_lap", i), lap_cnt, vecs[i].lap);
    end
    idle_inputs();

    // ---- two laps to target 1; start/illegal target held during run are ignored
    begin
      logic [2:0] exp_q_seq[10];
      int         n_done;
      logic [2:0] tmp[5];
      tmp[0] = 3'd7; tmp[1] = 3'd0; tmp[2] = 3'd2; tmp[3] = 3'd3; tmp[4] = 3'd1;
      for (int k = 0; k < 10; k++) exp_q_seq[k] = tmp[k % 5];
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 3'd1, 4'd1);
      cyc();
      chk("lap2_accept_busy", busy, 1);
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
        if (k < 3) drive(1'b1, 1'b0, 1'b0, 3'd5, 4'd0);
        else idle_inputs();
        cyc();
        chk($sformatf("lap2_q%0d", k), q, exp_q_seq[k]);
        chk($sformatf("lap2_err%0d", k), err, 0);
        if (done) n_done++;
        if (k == 4) chk("lap2_lap_mid", lap_cnt, 1);
      end
      chk("lap2_done_last", done, 1);
      chk("lap2_lap_end", lap_cnt, 2);
      chk("lap2_done_count", n_done, 1);
      cyc();
      chk("lap2_after_done", done, 0);
      chk("lap2_after_busy", busy, 0);
      chk("lap2_after_q", q, 1);
    end

    // ---- lap counter saturation: laps=15 needs 16 wraps, count stays 15
    begin
      int ncyc;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 3'd1, 4'd15);
      cyc();
      idle_inputs();
      ncyc = 0;
      while (!done && ncyc < 200) begin
        cyc();
        ncyc++;
      end
      chk("sat_cycles", ncyc, 80);
      chk("sat_lap", lap_cnt, 15);
      chk("sat_q", q, 1);
    end

    // ---- stop when q=0
    begin
      int n_done;
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 3'd3, 4'd2);
      cyc();
      idle_inputs();
      cyc();
      cyc();
      chk("stop_pre_q", q, 0);
      stop_req = 1'b1;
      cyc();
      stop_req = 1'b0;
      chk("stop_q", q, 0);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
      n_done = 0;
      for (int k = 0; k < 5; k++) begin
        cyc();
        if (done || busy || q != 3'd0) n_done++;
      end
      chk("stop_quiet", n_done, 0);
    end

    // ---- stop beats completion on the same edge
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 3'd7, 4'd0);
    cyc();
    drive(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    cyc();
    idle_inputs();
    chk("prio_q", q, 1);
    chk("prio_busy", busy, 0);
    chk("prio_done", done, 0);
    cyc();
    chk("prio_done2", done, 0);

    // ---- asynchronous reset mid-run
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 3'd3, 4'd2);
    cyc();
    idle_inputs();
    cyc();
    cyc();
    cyc();
    chk("arst_pre_q", q, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_q", q, 1);
    chk("arst_busy", busy, 0);
    chk("arst_lap", lap_cnt, 0);
    chk("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("arst_idle_q%0d", k), q, 1);
      chk($sformatf("arst_idle_busy%0d", k), busy, 0);
      chk($sformatf("arst_idle_done%0d", k), done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
